// File: rtl/reg_file_dump.sv
// R x N register file: two 1-cycle registered read ports with write bypass, plus a dump streamer.
// Dump words are snapshots taken when the word is loaded; dump_ready low holds the word and index.
module reg_file_dump #(
  parameter int N = 16,
  parameter int R = 8,
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [A-1:0] rd_addr_a,
  output logic [N-1:0] rd_data_a,
  input  logic [A-1:0] rd_addr_b,
  output logic [N-1:0] rd_data_b,
  input  logic         dump_start,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [A-1:0] dump_addr,
  output logic [N-1:0] dump_data,
  output logic         dump_busy
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t       state;
  logic [N-1:0] regs [R];
  logic [A-1:0] dump_sel;
  logic [N-1:0] byp_a, byp_b, byp_dump;
  logic         last_word;

  // Index of the word the dump loads next: reg 0 on start, otherwise the successor.
  always_comb begin
    dump_sel = (state == IDLE) ? '0 : dump_addr + A'(1);
    byp_a    = (wr_en && wr_addr == rd_addr_a) ? wr_data : regs[rd_addr_a];
    byp_b    = (wr_en && wr_addr == rd_addr_b) ? wr_data : regs[rd_addr_b];
    byp_dump = (wr_en && wr_addr == dump_sel)  ? wr_data : regs[dump_sel];
  end

  assign last_word = (dump_addr == A'(R - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < R; i++) regs[i] <= '0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      dump_addr  <= '0;
      dump_data  <= '0;
      dump_valid <= 1'b0;
      dump_busy  <= 1'b0;
      state      <= IDLE;
    end else begin
      if (wr_en) regs[wr_addr] <= wr_data;
      rd_data_a <= byp_a;
      rd_data_b <= byp_b;
      case (state)
        IDLE: begin
          if (dump_start) begin
            state      <= SEND;
            dump_addr  <= '0;
            dump_data  <= byp_dump;
            dump_valid <= 1'b1;
            dump_busy  <= 1'b1;
          end
        end
        SEND: begin
          if (dump_valid && dump_ready) begin
            if (last_word) begin
              state      <= IDLE;
              dump_valid <= 1'b0;
              dump_busy  <= 1'b0;
            end else begin
              dump_addr <= dump_sel;
              dump_data <= byp_dump;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_dump.sv
// Directed and randomized bench for reg_file_dump against a cycle-level array model.
module tb_reg_file_dump;
  localparam int N = 16;
  localparam int R = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst, wr_en, dump_start, dump_ready;
  logic [A-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [N-1:0] wr_data;
  logic [N-1:0] rd_data_a, rd_data_b, dump_data;
  logic [A-1:0] dump_addr;
  logic         dump_valid, dump_busy;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Reference model: register contents, expected outputs, log of accepted dump words.
  logic [N-1:0] mregs [R];
  logic [N-1:0] m_a, m_b, m_data;
  int           m_idx;
  bit           m_busy;
  int           log_idx [$];
  logic [N-1:0] log_dat [$];

  reg_file_dump #(.N(N), .R(R), .A(A)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data), .dump_busy(dump_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: predict from current inputs, step the edge, then compare every output.
  task automatic cycle();
    logic [N-1:0] nr [R];
    if (rst) begin
      for (int i = 0; i < R; i++) mregs[i] = '0;
      m_a = '0; m_b = '0; m_data = '0; m_idx = 0; m_busy = 0;
    end else begin
      nr = mregs;
      if (wr_en) nr[wr_addr] = wr_data;
      // A read returns what the register holds once this edge's write has landed.
      m_a = nr[rd_addr_a];
      m_b = nr[rd_addr_b];
      if (!m_busy && dump_start) begin
        m_busy = 1; m_idx = 0; m_data = nr[0];
      end else if (m_busy && dump_ready) begin
        log_idx.push_back(m_idx);
        log_dat.push_back(m_data);
        if (m_idx == R - 1) m_busy = 0;
        else begin
          m_idx++;
          m_data = nr[m_idx];
        end
      end
      mregs = nr;
    end
    @(posedge clk);
    #1;
    chk("rd_data_a", 32'(rd_data_a), 32'(m_a));
    chk("rd_data_b", 32'(rd_data_b), 32'(m_b));
    chk("dump_valid", 32'(dump_valid), 32'(m_busy));
    chk("dump_busy", 32'(dump_busy), 32'(m_busy));
    chk("dump_addr", 32'(dump_addr), 32'(m_idx));
    chk("dump_data", 32'(dump_data), 32'(m_data));
  endtask

  task automatic write(input int addr, input logic [N-1:0] data);
    wr_en = 1; wr_addr = A'(addr); wr_data = data;
    cycle();
    wr_en = 0;
  endtask

  initial begin
    int vcount;
    rst = 1; wr_en = 0; wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    dump_start = 0; dump_ready = 0;
    for (int i = 0; i < R; i++) mregs[i] = 'x;
    cycle();
    cycle();

    // Reset state: every register reads back zero on both ports.
    rst = 0;
    for (int i = 0; i < R; i++) begin
      rd_addr_a = A'(i); rd_addr_b = A'(R - 1 - i);
      cycle();
      chk("t1_rd_a_zero", 32'(rd_data_a), 32'h0);
      chk("t1_rd_b_zero", 32'(rd_data_b), 32'h0);
    end
    chk("t1_dump_valid", 32'(dump_valid), 32'h0);

    // Plain write then read.
    write(3, 16'hBEEF);
    write(5, 16'h1234);
    rd_addr_a = 3'd3; rd_addr_b = 3'd5;
    cycle();
    chk("t2_rd_a", 32'(rd_data_a), 32'hBEEF);
    chk("t2_rd_b", 32'(rd_data_b), 32'h1234);

    // Same-cycle write and read: bypass on both ports.
    rd_addr_a = 3'd2; rd_addr_b = 3'd2;
    write(2, 16'hA5A5);
    chk("t3_bypass_a", 32'(rd_data_a), 32'hA5A5);
    chk("t3_bypass_b", 32'(rd_data_b), 32'hA5A5);

    // Full-rate dump.
    for (int i = 0; i < R; i++) write(i, N'(i * 16'h0101));
    log_idx.delete(); log_dat.delete();
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    vcount = int'(dump_valid);
    for (int k = 0; k < 12; k++) begin
      cycle();
      vcount += int'(dump_valid);
    end
    chk("t4_valid_cycles", 32'(vcount), 32'd8);
    chk("t4_done_busy", 32'(dump_busy), 32'h0);
    chk("t4_word_count", 32'(log_idx.size()), 32'd8);
    for (int i = 0; i < log_idx.size() && i < R; i++) begin
      chk("t4_word_addr", 32'(log_idx[i]), 32'(i));
      chk("t4_word_data", 32'(log_dat[i]), 32'(i * 16'h0101));
    end

    // Stalled dump with a write to the held register.
    log_idx.delete(); log_dat.delete();
    dump_start = 1; dump_ready = 0;
    cycle();
    dump_start = 0;
    for (int k = 0; k < 40 && dump_busy; k++) begin
      dump_ready = (k % 3 == 0);
      if (k == 1) write(1, 16'hFFFF);
      else cycle();
      if (k == 1 || k == 2) begin
        chk("t5_stall_addr", 32'(dump_addr), 32'd1);
        chk("t5_stall_data", 32'(dump_data), 32'h0101);
      end
    end
    chk("t5_done_busy", 32'(dump_busy), 32'h0);
    chk("t5_word_count", 32'(log_idx.size()), 32'd8);
    for (int i = 0; i < log_idx.size() && i < R; i++) begin
      chk("t5_word_addr", 32'(log_idx[i]), 32'(i));
      chk("t5_word_data", 32'(log_dat[i]), 32'(i * 16'h0101));
    end

    // Reset mid-dump, then restart.
    dump_start = 1; dump_ready = 1;
    cycle();
    dump_start = 0;
    repeat (4) cycle();
    chk("t6_addr_before_rst", 32'(dump_addr), 32'd4);
    rst = 1;
    cycle();
    rst = 0; dump_ready = 0;
    chk("t6_valid_after_rst", 32'(dump_valid), 32'h0);
    chk("t6_busy_after_rst", 32'(dump_busy), 32'h0);
    for (int i = 0; i < R; i++) begin
      rd_addr_a = A'(i); rd_addr_b = A'(i);
      cycle();
      chk("t6_reg_zero", 32'(rd_data_a), 32'h0);
    end
    dump_start = 1;
    cycle();
    dump_start = 0;
    chk("t6_restart_valid", 32'(dump_valid), 32'h1);
    chk("t6_restart_addr", 32'(dump_addr), 32'h0);
    chk("t6_restart_data", 32'(dump_data), 32'h0);

    // Random traffic: writes, reads, dumps, backpressure and occasional resets.
    for (int k = 0; k < 600; k++) begin
      rst        = ($urandom_range(0, 99) == 0);
      wr_en      = $urandom_range(0, 1);
      wr_addr    = A'($urandom_range(0, R - 1));
      wr_data    = N'($urandom);
      rd_addr_a  = A'($urandom_range(0, R - 1));
      rd_addr_b  = ($urandom_range(0, 3) == 0) ? wr_addr : A'($urandom_range(0, R - 1));
      dump_start = ($urandom_range(0, 5) == 0);
      dump_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
